// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the console address.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] MMIO_ADDR_DEF = 32'h1000_0000;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } lsu_state_e;

    // Illegal size or an address not aligned to the access size.
    function automatic logic size_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling: load extract/extend, store lane shift and read-modify-write merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] st_shifted,
    output logic [31:0] st_merged,
    output logic [31:0] ld_data
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shamt      = {addr_lo, 3'b000};
        st_shifted = wdata << shamt;

        case (size)
            SZ_B:    lane_mask = 32'h0000_00FF << shamt;
            SZ_H:    lane_mask = 32'h0000_FFFF << shamt;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        // Only the addressed lanes take the new data; the rest keep the word read back.
        st_merged = (rword & ~lane_mask) | (st_shifted & lane_mask);

        byte_v = 8'(rword >> shamt);
        half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (size)
            SZ_B:    ld_data = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    ld_data = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: ld_data = rword;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-only, multi-cycle dmem; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEF,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  al_size;
    logic        al_unsigned;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [31:0] al_shifted;
    logic [31:0] al_merged;
    logic [31:0] al_load;

    // In IDLE the aligner sees the incoming request so the store shift is ready at acceptance.
    always_comb begin
        al_size     = (state_q == IDLE) ? req_size        : size_q;
        al_unsigned = (state_q == IDLE) ? req_unsigned    : unsigned_q;
        al_addr_lo  = (state_q == IDLE) ? req_addr[1:0]   : addr_q[1:0];
        al_wdata    = (state_q == IDLE) ? req_wdata       : wdata_q;
    end

    lsu_align u_align (
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .addr_lo     (al_addr_lo),
        .wdata       (al_wdata),
        .rword       (mem_rdata),
        .st_shifted  (al_shifted),
        .st_merged   (al_merged),
        .ld_data     (al_load)
    );

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    if (size_err(req_size, req_addr[1:0])) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = RESP;
                    end else begin
                        mem_addr_d  = (req_addr == MMIO_ADDR) ? req_addr : {req_addr[31:2], 2'b00};
                        mem_wdata_d = al_shifted;
                        if (req_store && (req_size == SZ_W || req_addr == MMIO_ADDR))
                            state_d = WR_ISSUE;
                        else
                            state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                cnt_d   = 8'h0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    if (store_q) begin
                        mem_wdata_d = al_merged;
                        state_d     = WR_ISSUE;
                    end else begin
                        resp_rdata_d = al_load;
                        resp_err_d   = 1'b0;
                        state_d      = RESP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            WR_ISSUE: begin
                cnt_d   = 8'h0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end else if (cnt_q == TO_LAST) begin
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            RESP: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            cnt_q        <= 8'h0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = (state_q == RD_ISSUE);
    assign mem_write  = (state_q == WR_ISSUE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural multi-cycle dmem and a response scoreboard.
module tb_load_store_unit;

  localparam int MEM_DELAY = 3;
  localparam logic [31:0] MMIO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];

  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  logic        stall = 1'b0;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural dmem: ready drops after a pulse and returns MEM_DELAY+1 cycles later
  logic [31:0] mem_arr [0:255];
  logic        busy;
  int          dcnt;
  logic        op_wr;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b1;
      mem_rdata <= 32'h0;
      busy      <= 1'b0;
      dcnt      <= 0;
      op_wr     <= 1'b0;
      op_addr   <= 32'h0;
      op_wdata  <= 32'h0;
    end else if (mem_read || mem_write) begin
      mem_ready <= 1'b0;
      busy      <= 1'b1;
      dcnt      <= MEM_DELAY;
      op_wr     <= mem_write;
      op_addr   <= mem_addr;
      op_wdata  <= mem_wdata;
    end else if (busy && !stall) begin
      if (dcnt == 1) begin
        mem_ready <= 1'b1;
        busy      <= 1'b0;
        if (op_wr) begin
          if (op_addr != MMIO) mem_arr[op_addr[9:2]] <= op_wdata;
        end else begin
          mem_rdata <= mem_arr[op_addr[9:2]];
        end
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one request, monitored until its response; expectations go through the scoreboard
  task automatic do_req(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                        input int e_rd, input int e_wr);
    int cyc, lat, n_rd, n_wr, viol;
    logic prev_rd, prev_wr, got, r_err;
    logic [31:0] r_data;
    logic [31:0] x_rdata;
    logic        x_err;
    int          x_lat;
    exp_rdata_q.push_back(e_rdata);
    exp_err_q.push_back(e_err);
    exp_lat_q.push_back(e_lat);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; lat = 0; n_rd = 0; n_wr = 0; viol = 0;
    prev_rd = 1'b0; prev_wr = 1'b0; got = 1'b0; r_err = 1'b0; r_data = 32'h0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_read) n_rd++;
      if (mem_write) begin
        n_wr++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      if ((mem_read && mem_write) || (mem_read && prev_rd) || (mem_write && prev_wr)) viol++;
      prev_rd = mem_read;
      prev_wr = mem_write;
      if (resp_valid) begin
        got = 1'b1; lat = cyc; r_data = resp_rdata; r_err = resp_err;
      end
    end
    check({tag, " resp_seen"}, {31'h0, got}, 32'h1);
    x_rdata = exp_rdata_q.pop_front();
    x_err   = exp_err_q.pop_front();
    x_lat   = exp_lat_q.pop_front();
    if (got) begin
      check({tag, " rdata"}, r_data, x_rdata);
      check({tag, " err"}, {31'h0, r_err}, {31'h0, x_err});
      check({tag, " latency"}, lat, x_lat);
      check({tag, " reads"}, n_rd, e_rd);
      check({tag, " writes"}, n_wr, e_wr);
      check({tag, " pulse_rule"}, viol, 0);
      @(negedge clk);
      check({tag, " resp_one_cycle"}, {31'h0, resp_valid}, 32'h0);
      check({tag, " ready_after"}, {31'h0, req_ready}, 32'h1);
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] a;

    // reset values
    repeat (2) @(negedge clk);
    check("rst req_ready", {31'h0, req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst resp_err", {31'h0, resp_err}, 32'h0);
    check("rst rw", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // word store / load
    do_req("sw", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, 6, 0, 1);
    check("sw waddr", last_waddr, 32'h40);
    check("sw wdata", last_wdata, 32'hDEAD_BEEF);
    do_req("lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 6, 1, 0);

    // byte RMW
    do_req("sw init", 1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, 32'h0, 1'b0, 6, 0, 1);
    do_req("sb rmw", 1'b1, 2'd0, 1'b0, 32'h41, 32'hAAAA_AA80, 32'h0, 1'b0, 11, 1, 1);
    check("sb waddr", last_waddr, 32'h40);
    check("sb merged", last_wdata, 32'h1122_8044);
    do_req("lb", 1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 32'hFFFF_FF80, 1'b0, 6, 1, 0);
    do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 32'h0000_0080, 1'b0, 6, 1, 0);

    // half RMW
    do_req("sw init2", 1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, 32'h0, 1'b0, 6, 0, 1);
    do_req("sh rmw", 1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_BEEF, 32'h0, 1'b0, 11, 1, 1);
    check("sh merged", last_wdata, 32'hBEEF_3344);
    do_req("lh", 1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 32'hFFFF_BEEF, 1'b0, 6, 1, 0);
    do_req("lhu", 1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'h0000_BEEF, 1'b0, 6, 1, 0);
    do_req("lw merged", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hBEEF_3344, 1'b0, 6, 1, 0);

    // alignment / size errors
    do_req("lw mis", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("lh mis", 1'b0, 2'd1, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("size3", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sw mis", 1'b1, 2'd2, 1'b0, 32'h42, 32'h5555_5555, 32'h0, 1'b1, 1, 0, 0);

    // console store bypasses RMW
    do_req("mmio sb", 1'b1, 2'd0, 1'b0, MMIO, 32'h0000_0041, 32'h0, 1'b0, 6, 0, 1);
    check("mmio waddr", last_waddr, 32'h1000_0000);
    check("mmio wdata", last_wdata, 32'h0000_0041);

    // random byte and half round trips
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      a = 32'h100 + 32'($urandom_range(0, 15));
      do_req("rnd sb", 1'b1, 2'd0, 1'b0, a, {24'hC3C3C3, b}, 32'h0, 1'b0, 11, 1, 1);
      do_req("rnd lb", 1'b0, 2'd0, 1'b0, a, 32'h0, {{24{b[7]}}, b}, 1'b0, 6, 1, 0);
      do_req("rnd lbu", 1'b0, 2'd0, 1'b1, a, 32'h0, {24'h0, b}, 1'b0, 6, 1, 0);
      h = 16'($urandom_range(0, 65535));
      a = 32'h120 + {28'h0, 3'($urandom_range(0, 7)), 1'b0};
      do_req("rnd sh", 1'b1, 2'd1, 1'b0, a, {16'h5A5A, h}, 32'h0, 1'b0, 11, 1, 1);
      do_req("rnd lh", 1'b0, 2'd1, 1'b0, a, 32'h0, {{16{h[15]}}, h}, 1'b0, 6, 1, 0);
    end

    // reset while in RD_WAIT
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h44; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst busy", {31'h0, req_ready}, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst rw", {30'h0, mem_read, mem_write}, 32'h0);
    check("midrst resp", {30'h0, resp_valid, resp_err}, 32'h0);
    check("midrst mem_addr", mem_addr, 32'h0);
    check("midrst mem_wdata", mem_wdata, 32'h0);
    check("midrst resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_req("lw after rst", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hBEEF_3344, 1'b0, 6, 1, 0);

    // dmem never completes: abort after 15 WAIT cycles
    stall = 1'b1;
    do_req("timeout ld", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 17, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b0;
    do_req("sw after to", 1'b1, 2'd2, 1'b0, 32'h48, 32'h0BAD_F00D, 32'h0, 1'b0, 6, 0, 1);
    stall = 1'b1;
    do_req("timeout st", 1'b1, 2'd2, 1'b0, 32'h48, 32'h1234_5678, 32'h0, 1'b1, 17, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
